// File: rtl/shared_vc_input_buffer_pkg.sv
// ----------------------------------------------------------------------------
// shared_vc_input_buffer_pkg
// Router-wide NoC parameters and types shared by the input-port flit buffer:
// flit format, VC count, and the default size of the shared slot pool.
// ----------------------------------------------------------------------------
package shared_vc_input_buffer_pkg;

   localparam int VC_NUM            = 2;
   localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int DATA_W            = 16;
   localparam int POOL_SIZE_DEFAULT = 16;

   typedef logic [$clog2(POOL_SIZE_DEFAULT)-1:0] slot_idx_t;

   typedef struct packed {
      logic [VC_SIZE-1:0] vc_id;
      logic [DATA_W-1:0]  data;
   } flit_t;

endpackage

// File: rtl/shared_vc_input_buffer_slot_free_list.sv
// ----------------------------------------------------------------------------
// slot_free_list
// Circular FIFO of free slot indices for the shared flit pool. On reset it
// holds every index 0..POOL_SIZE-1 in order. One allocation (pop) and one
// release (push) may happen in the same cycle. A pushed index only becomes
// poppable once it has worked its way to the head, so a slot released this
// cycle is never handed out in the same cycle.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_pop        take the index at o_idx this cycle
//   o_idx        index at the head of the free list
//   i_push       return i_push_idx to the free list
//   i_push_idx   slot index being released
//   o_count      number of free slots
// ----------------------------------------------------------------------------
module slot_free_list #(
   parameter int POOL_SIZE = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_pop,
   output logic [$clog2(POOL_SIZE)-1:0]   o_idx,
   input  logic                           i_push,
   input  logic [$clog2(POOL_SIZE)-1:0]   i_push_idx,
   output logic [$clog2(POOL_SIZE+1)-1:0] o_count
);

   localparam int IDX_W = $clog2(POOL_SIZE);
   localparam int CNT_W = $clog2(POOL_SIZE+1);

   logic [IDX_W-1:0] r_mem [POOL_SIZE];
   logic [IDX_W-1:0] r_rd_ptr;
   logic [IDX_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   // Explicit wrap so POOL_SIZE need not be a power of two.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      return (p == IDX_W'(POOL_SIZE-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < POOL_SIZE; i++) begin
            r_mem[i] <= IDX_W'(i);
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= CNT_W'(POOL_SIZE);
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_idx;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (i_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_idx   = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/shared_vc_input_buffer.sv
// ----------------------------------------------------------------------------
// shared_vc_input_buffer
// Per-input-port flit store built on one shared pool of POOL_SIZE slots.
// Every VC owns RESERVED guaranteed slots; the rest are shared first-come.
// Per-VC order is kept with a linked list (next-pointer RAM, head/tail/count
// per VC). on_off_o tells upstream whether another flit for that VC would be
// accepted, keeping OFF_THRESHOLD shared slots in hand for the link round trip.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   data_i          incoming flit, target VC in data_i.vc_id
//   valid_flit_i    data_i valid this cycle
//   rd_valid_i      pop head flit of VC rd_vc_i
//   rd_vc_i         VC presented on flit_o / popped
//   flit_o          head flit of rd_vc_i (undefined when that VC is empty)
//   is_empty_o      per-VC empty
//   on_off_o        registered per-VC accept permission to upstream
//   error_o         sticky per-VC protocol error (refused write / empty read)
// Optional (macro SHARED_BUF_STATS_EN):
//   occupancy_o     per-VC flit count
//   peak_shared_o   highest shared-slot usage since reset
// ----------------------------------------------------------------------------
module shared_vc_input_buffer
   import shared_vc_input_buffer_pkg::*;
#(
   parameter int POOL_SIZE     = POOL_SIZE_DEFAULT,
   parameter int RESERVED      = 2,
   parameter int OFF_THRESHOLD = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  flit_t               data_i,
   input  logic                valid_flit_i,
   input  logic                rd_valid_i,
   input  logic [VC_SIZE-1:0]  rd_vc_i,
   output flit_t               flit_o,
   output logic [VC_NUM-1:0]   is_empty_o,
   output logic [VC_NUM-1:0]   on_off_o,
   output logic [VC_NUM-1:0]   error_o
`ifdef SHARED_BUF_STATS_EN
   ,
   output logic [VC_NUM-1:0][$clog2(POOL_SIZE+1)-1:0] occupancy_o,
   output logic [$clog2(POOL_SIZE+1)-1:0]             peak_shared_o
`endif
);

   localparam int IDX_W        = $clog2(POOL_SIZE);
   localparam int CNT_W        = $clog2(POOL_SIZE+1);
   localparam int SHARED_TOTAL = POOL_SIZE - VC_NUM*RESERVED;

   typedef logic [VC_NUM-1:0][CNT_W-1:0] cnt_vec_t;

   flit_t            r_flit_ram [POOL_SIZE];
   logic [IDX_W-1:0] r_next_ram [POOL_SIZE];
   logic [IDX_W-1:0] r_head     [VC_NUM];
   logic [IDX_W-1:0] r_tail     [VC_NUM];
   cnt_vec_t         r_count;
   logic [VC_NUM-1:0] r_on_off;
   logic [VC_NUM-1:0] r_error;

   logic [IDX_W-1:0]   w_alloc_idx;
   logic [CNT_W-1:0]   w_free_count;
   logic [VC_SIZE-1:0] w_wr_vc;
   logic               w_wr_room;
   logic               w_wr_ok;
   logic               w_wr_err;
   logic               w_rd_ok;
   logic               w_rd_err;
   logic [IDX_W-1:0]   w_rd_idx;
   logic [VC_NUM-1:0]  w_wr_hit;
   logic [VC_NUM-1:0]  w_rd_hit;
   logic [VC_NUM-1:0]  w_err_vec;
   cnt_vec_t           w_count_next;
   logic [CNT_W-1:0]   w_shared_free;
   logic [CNT_W-1:0]   w_shared_used_next;
   logic [CNT_W-1:0]   w_shared_free_next;

   // Shared slots in use: whatever each VC holds beyond its reservation.
   function automatic logic [CNT_W-1:0] shared_used_of(input cnt_vec_t cnt);
      logic [CNT_W-1:0] acc;
      acc = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (cnt[v] > CNT_W'(RESERVED)) begin
            acc = acc + (cnt[v] - CNT_W'(RESERVED));
         end
      end
      return acc;
   endfunction

   slot_free_list #(.POOL_SIZE(POOL_SIZE)) u_free_list (
      .clk        (clk),
      .rst        (rst),
      .i_pop      (w_wr_ok),
      .o_idx      (w_alloc_idx),
      .i_push     (w_rd_ok),
      .i_push_idx (w_rd_idx),
      .o_count    (w_free_count)
   );

   always_comb begin
      w_wr_vc       = data_i.vc_id;
      w_shared_free = CNT_W'(SHARED_TOTAL) - shared_used_of(r_count);
      w_wr_room     = (r_count[w_wr_vc] < CNT_W'(RESERVED)) || (w_shared_free != '0);
      w_wr_ok       = valid_flit_i && w_wr_room;
      w_wr_err      = valid_flit_i && !w_wr_room;
      w_rd_ok       = rd_valid_i && (r_count[rd_vc_i] != '0);
      w_rd_err      = rd_valid_i && (r_count[rd_vc_i] == '0);
      w_rd_idx      = r_head[rd_vc_i];
      for (int v = 0; v < VC_NUM; v++) begin
         w_wr_hit[v]     = w_wr_ok && (w_wr_vc == VC_SIZE'(v));
         w_rd_hit[v]     = w_rd_ok && (rd_vc_i == VC_SIZE'(v));
         w_err_vec[v]    = (w_wr_err && (w_wr_vc == VC_SIZE'(v))) ||
                           (w_rd_err && (rd_vc_i == VC_SIZE'(v)));
         w_count_next[v] = r_count[v] + CNT_W'(w_wr_hit[v]) - CNT_W'(w_rd_hit[v]);
      end
      w_shared_used_next = shared_used_of(w_count_next);
      w_shared_free_next = CNT_W'(SHARED_TOTAL) - w_shared_used_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int v = 0; v < VC_NUM; v++) begin
            r_head[v] <= '0;
            r_tail[v] <= '0;
         end
         r_count  <= '0;
         r_on_off <= '1;
         r_error  <= '0;
      end else begin
         r_count <= w_count_next;
         for (int v = 0; v < VC_NUM; v++) begin
            r_on_off[v] <= (w_count_next[v] < CNT_W'(RESERVED)) ||
                           (w_shared_free_next >= CNT_W'(OFF_THRESHOLD));
         end
         if (w_wr_ok) begin
            r_tail[w_wr_vc] <= w_alloc_idx;
            if (r_count[w_wr_vc] == '0) begin
               r_head[w_wr_vc] <= w_alloc_idx;
            end
         end
         if (w_rd_ok) begin
            // Popping the only flit while a new one arrives: the link from the
            // old tail is written this same edge, so take the new slot directly.
            if (w_wr_ok && (w_wr_vc == rd_vc_i) && (r_count[rd_vc_i] == CNT_W'(1))) begin
               r_head[rd_vc_i] <= w_alloc_idx;
            end else begin
               r_head[rd_vc_i] <= r_next_ram[w_rd_idx];
            end
         end
         r_error <= r_error | w_err_vec;
      end
   end

   // Storage arrays carry no reset; validity is tracked by the per-VC counts.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_flit_ram[w_alloc_idx] <= data_i;
         if (r_count[w_wr_vc] != '0) begin
            r_next_ram[r_tail[w_wr_vc]] <= w_alloc_idx;
         end
      end
   end

   always_comb begin
      flit_o = r_flit_ram[r_head[rd_vc_i]];
      for (int v = 0; v < VC_NUM; v++) begin
         is_empty_o[v] = (r_count[v] == '0);
      end
   end

   assign on_off_o = r_on_off;
   assign error_o  = r_error;

`ifdef SHARED_BUF_STATS_EN
   // Width holds POOL_SIZE, above the largest possible shared usage, so the
   // peak can never wrap.
   logic [CNT_W-1:0] r_peak_shared;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_peak_shared <= '0;
      end else if (w_shared_used_next > r_peak_shared) begin
         r_peak_shared <= w_shared_used_next;
      end
   end

   assign occupancy_o   = r_count;
   assign peak_shared_o = r_peak_shared;
`endif

`ifndef SYNTHESIS
   int w_count_sum;

   always_comb begin
      w_count_sum = 0;
      for (int v = 0; v < VC_NUM; v++) begin
         w_count_sum = w_count_sum + int'(r_count[v]);
      end
   end

   a_pool_conserved: assert property (@(posedge clk) disable iff (rst)
      (int'(w_free_count) + w_count_sum) == POOL_SIZE);
`endif

endmodule
